// File: rtl/wddl_pkg.sv
// Shared types and constants for the WDDL precharge/evaluate sequencer.
// The optional rail checker in the top is enabled with the WDDL_RAILCHK_EN macro.
package wddl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        OUT  = 2'd3
    } wddl_phase_e;

    localparam int WDDL_PRE_CYCLES_DEF  = 2;
    localparam int WDDL_EVAL_CYCLES_DEF = 3;

    // Phase counter width: enough to reach the longer phase, plus headroom.
    function automatic int wddl_cnt_width(input int pre_cycles, input int eval_cycles);
        int longest;
        longest = (pre_cycles > eval_cycles) ? pre_cycles : eval_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/wddl_phase_cnt.sv
// Clear/increment phase counter with a terminal-count compare against a limit
// supplied at run time, so one instance serves both the PRE and EVAL phases.
module wddl_phase_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else if (inc_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc_o = (cnt == limit_i);

endmodule

// File: rtl/wddl_phase_ctrl.sv
// Sequencer for a WDDL dual-rail datapath: precharge, evaluate, capture, present.
// Define WDDL_RAILCHK_EN to add err_o with complement and precharge-leak checks.
module wddl_phase_ctrl
    import wddl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRE_CYCLES  = WDDL_PRE_CYCLES_DEF,
    parameter int EVAL_CYCLES = WDDL_EVAL_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic [WIDTH-1:0] dp_a_o,
    output logic [WIDTH-1:0] dp_b_o,
    output logic             prechrg_o,
    input  logic [WIDTH-1:0] dp_t_i,
    input  logic [WIDTH-1:0] dp_f_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
`ifdef WDDL_RAILCHK_EN
    output logic             err_o,
`endif
    output wddl_phase_e      state_o
);

    localparam int CNT_W = wddl_cnt_width(PRE_CYCLES, EVAL_CYCLES);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYCLES - 1);

    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    // The counter only runs in PRE/EVAL; it is cleared everywhere else and on
    // its terminal count, so each phase starts from zero without wrapping.
    always_comb begin
        cnt_limit = PRE_LAST;
        cnt_inc   = 1'b0;
        if (state_o == EVAL) begin
            cnt_limit = EVAL_LAST;
        end
        if ((state_o == PRE || state_o == EVAL) && !cnt_tc) begin
            cnt_inc = 1'b1;
        end
        cnt_clr = !cnt_inc;
    end

    wddl_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    // Handshakes: a beat moves on a rising edge where valid and ready are both
    // high; the side holding valid keeps its data stable until that edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_o     <= IDLE;
            prechrg_o   <= 1'b1;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            dp_a_o      <= '0;
            dp_b_o      <= '0;
            out_data_o  <= '0;
        end else begin
            case (state_o)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        dp_a_o     <= in_a_i;
                        dp_b_o     <= in_b_i;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state_o    <= PRE;
                    end
                end
                PRE: begin
                    if (cnt_tc) begin
                        prechrg_o <= 1'b0;
                        state_o   <= EVAL;
                    end
                end
                EVAL: begin
                    // Precharge is reasserted together with the capture, so the
                    // datapath is back to all-zero while the result is presented.
                    if (cnt_tc) begin
                        out_data_o  <= dp_t_i;
                        prechrg_o   <= 1'b1;
                        out_valid_o <= 1'b1;
                        state_o     <= OUT;
                    end
                end
                OUT: begin
                    if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                        state_o     <= IDLE;
                    end
                end
                default: begin
                    prechrg_o   <= 1'b1;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state_o     <= IDLE;
                end
            endcase
        end
    end

`ifdef WDDL_RAILCHK_EN
    logic rail_not_compl;
    logic rail_leak;

    assign rail_not_compl = ((dp_t_i ^ dp_f_i) != {WIDTH{1'b1}});
    assign rail_leak      = ((dp_t_i | dp_f_i) != '0);

    // Sticky until reset: one bad evaluation is enough to flag the datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (state_o == EVAL && cnt_tc && rail_not_compl) begin
            err_o <= 1'b1;
        end else if (state_o == PRE && cnt_tc && rail_leak) begin
            err_o <= 1'b1;
        end
    end
`else
    logic unused_rail;
    assign unused_rail = ^dp_f_i;
`endif

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// Self-checking bench for wddl_phase_ctrl with a bitwise-OR dual-rail datapath model.
// Rail-check steps run only when WDDL_RAILCHK_EN is defined.
module tb_wddl_phase_ctrl;
    import wddl_pkg::*;

    localparam int W    = 8;
    localparam int PRE  = 2;
    localparam int EVAL = 3;
    localparam int LAT  = PRE + EVAL + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] dp_a;
    logic [W-1:0] dp_b;
    logic         prechrg;
    logic [W-1:0] dp_t;
    logic [W-1:0] dp_f;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    wddl_phase_e  state;
    logic         leak;
    logic         bad_f;
`ifdef WDDL_RAILCHK_EN
    logic         err;
    logic         err_exp;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    wddl_phase_ctrl #(
        .WIDTH       (W),
        .PRE_CYCLES  (PRE),
        .EVAL_CYCLES (EVAL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .dp_a_o      (dp_a),
        .dp_b_o      (dp_b),
        .prechrg_o   (prechrg),
        .dp_t_i      (dp_t),
        .dp_f_i      (dp_f),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy),
`ifdef WDDL_RAILCHK_EN
        .err_o       (err),
`endif
        .state_o     (state)
    );

    // Datapath: OR on the true rail, its complement on the false rail, all-zero in precharge.
    assign dp_t = prechrg ? (leak ? 8'h01 : 8'h00) : (dp_a | dp_b);
    assign dp_f = prechrg ? 8'h00 : (~(dp_a | dp_b) ^ (bad_f ? 8'h01 : 8'h00));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_prechrg"}, prechrg, 1);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, 32'(state), 32'(IDLE));
`ifdef WDDL_RAILCHK_EN
        chk({tag, "_err"}, err, err_exp);
`endif
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge of the next idle cycle.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                           input logic chain, input logic [W-1:0] na, input logic [W-1:0] nb);
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        exp_q.push_back(a | b);
        for (int k = 1; k <= LAT + hold; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (chain) begin
                    in_a = na;
                    in_b = nb;
                end else begin
                    in_valid = 1'b0;
                end
            end
            chk("prechrg", prechrg, (k >= PRE + 1 && k <= PRE + EVAL) ? 0 : 1);
            chk("in_ready_busy", {in_ready, busy}, 2'b01);
            chk("dp_ops", {dp_a, dp_b}, {a, b});
            chk("out_valid", out_valid, (k >= LAT) ? 1 : 0);
            if (k >= LAT) chk("out_data", out_data, exp_q[0]);
            out_ready = (k == LAT + hold);
        end
        @(negedge clk);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        idle_chk("post_txn");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] cur_a, cur_b, nxt_a, nxt_b;
        logic         chain;
        int           hold;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        leak = 1'b0; bad_f = 1'b0;
`ifdef WDDL_RAILCHK_EN
        err_exp = 1'b0;
`endif

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_chk("reset");
        chk("reset_out_data", out_data, 0);
        chk("reset_dp_ops", {dp_a, dp_b}, 0);
        rst = 1'b0;

        // Single transaction, then back-pressure for 10 cycles.
        run_txn(8'h3C, 8'h81, 0, 1'b0, 8'h00, 8'h00);
        chk("single_result_const", (8'h3C | 8'h81), 8'hBD);
        run_txn(8'h5A, 8'h24, 10, 1'b0, 8'h00, 8'h00);

        // Back-to-back with in_valid held high through the first transaction.
        run_txn(8'h01, 8'h02, 0, 1'b1, 8'h10, 8'h20);
        run_txn(8'h10, 8'h20, 0, 1'b0, 8'h00, 8'h00);

        // Reset pulsed during EVAL discards the operation.
        in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (PRE + 1) @(negedge clk);
        chk("mid_rst_in_eval", prechrg, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_chk("mid_rst");
        chk("mid_rst_out_data", out_data, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", out_valid, 0);
        end

        // Randomized transactions with random back-pressure, chaining and idle gaps.
        cur_a = W'($urandom_range(0, 255));
        cur_b = W'($urandom_range(0, 255));
        for (int n = 0; n < 24; n++) begin
            nxt_a = W'($urandom_range(0, 255));
            nxt_b = W'($urandom_range(0, 255));
            hold  = $urandom_range(0, 3);
            chain = (n != 23) && ($urandom_range(0, 1) == 1);
            run_txn(cur_a, cur_b, hold, chain, nxt_a, nxt_b);
            if (!chain) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    idle_chk("gap");
                end
            end
            cur_a = nxt_a;
            cur_b = nxt_b;
        end

`ifdef WDDL_RAILCHK_EN
        // Non-complementary rail at capture sets err_o, which stays set.
        bad_f   = 1'b1;
        err_exp = 1'b1;
        run_txn(8'h33, 8'h44, 0, 1'b0, 8'h00, 8'h00);
        bad_f = 1'b0;
        run_txn(8'h01, 8'h80, 1, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_exp = 1'b0;
        idle_chk("err_cleared");
        // Nonzero true rail during precharge is flagged as a leak.
        leak    = 1'b1;
        err_exp = 1'b1;
        run_txn(8'h0C, 8'h30, 0, 1'b0, 8'h00, 8'h00);
        leak = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
